// File: rtl/sim_run_ctrl_pkg.sv
// Shared types and constants for the simulation run controller.
//   state_e         : run controller FSM states
//   EXIT_OK         : exit code value meaning success
//   hart_idx_width  : width of a hart index, never less than one bit
package sim_run_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  localparam int unsigned EXIT_OK = 0;

  function automatic int unsigned hart_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_eoc_tracker.sv
// Per-hart end-of-computation bookkeeping.
//   clk_i, rst_ni   : clock, async active-low reset
//   en_i            : accept EOC reports this cycle
//   eoc_valid_i     : per-hart EOC pulse
//   eoc_code_i      : per-hart exit code, hart h at [h*CodeWidth +: CodeWidth]
//   hart_done_o     : sticky per-hart done bits
//   exit_code_o     : first nonzero code accepted, else 0
//   fail_hart_o     : hart that supplied exit_code_o
//   all_done_c      : every hart done once this cycle's reports are included
//   fail_seen_c     : a nonzero code accepted so far, including this cycle
module sim_eoc_tracker
  import sim_run_ctrl_pkg::*;
#(
  parameter int unsigned NrHarts   = 9,
  parameter int unsigned CodeWidth = 32,
  localparam int unsigned HartW    = hart_idx_width(NrHarts)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic [NrHarts-1:0]           eoc_valid_i,
  input  logic [NrHarts*CodeWidth-1:0] eoc_code_i,
  output logic [NrHarts-1:0]           hart_done_o,
  output logic [CodeWidth-1:0]         exit_code_o,
  output logic [HartW-1:0]             fail_hart_o,
  output logic                         all_done_c,
  output logic                         fail_seen_c
);

  logic [NrHarts-1:0]   done_q, accept, done_d;
  logic [CodeWidth-1:0] code [NrHarts];
  logic [CodeWidth-1:0] exit_code_q, new_code;
  logic [HartW-1:0]     fail_hart_q, new_hart;
  logic                 fail_q, new_fail;

  // Unpack the flat code bus into one word per hart.
  for (genvar g = 0; g < NrHarts; g++) begin : g_code
    assign code[g] = eoc_code_i[g*CodeWidth +: CodeWidth];
  end

  // Accept first reports only; lowest-index failure wins within a cycle.
  always_comb begin
    accept   = eoc_valid_i & ~done_q & {NrHarts{en_i}};
    done_d   = done_q | accept;
    new_fail = 1'b0;
    new_code = CodeWidth'(EXIT_OK);
    new_hart = '0;
    for (int unsigned h = 0; h < NrHarts; h++) begin
      if (accept[h] && !new_fail && code[h] != CodeWidth'(EXIT_OK)) begin
        new_fail = 1'b1;
        new_code = code[h];
        new_hart = HartW'(h);
      end
    end
  end

  // Sticky done bits and first-failure capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q      <= '0;
      fail_q      <= 1'b0;
      exit_code_q <= CodeWidth'(EXIT_OK);
      fail_hart_q <= '0;
    end else begin
      done_q <= done_d;
      if (!fail_q && new_fail) begin
        fail_q      <= 1'b1;
        exit_code_q <= new_code;
        fail_hart_q <= new_hart;
      end
    end
  end

  assign hart_done_o = done_q;
  assign exit_code_o = exit_code_q;
  assign fail_hart_o = fail_hart_q;
  assign all_done_c  = &done_d;
  assign fail_seen_c = fail_q | new_fail;

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller for the cluster bench: DUT reset hold, run-cycle counting,
// EOC collection and pass/fail/timeout verdict.
//   clk_i, rst_ni : bench clock, async active-low reset
//   dut_rst_no    : DUT reset, released ResetCycles edges after rst_ni
//   eoc_valid_i   : per-hart EOC pulse
//   eoc_code_i    : per-hart exit code (0 = success)
//   hart_done_o   : sticky per-hart EOC seen
//   cycle_cnt_o   : cycles spent in RUN (saturating)
//   done_o        : run finished, pass_o/timeout_o give the verdict
//   exit_code_o   : first nonzero code, fail_hart_o its hart
// Optional macro SIM_RUN_CTRL_FINISH_EN: print a status line and end the
// simulation once done_o is set (simulation only, dropped under SYNTHESIS).
module sim_run_ctrl
  import sim_run_ctrl_pkg::*;
#(
  parameter int unsigned NrHarts       = 9,
  parameter int unsigned CodeWidth     = 32,
  parameter int unsigned CntWidth      = 32,
  parameter int unsigned ResetCycles   = 4,
  parameter int unsigned TimeoutCycles = 100000,
  localparam int unsigned HartW        = hart_idx_width(NrHarts)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic                         dut_rst_no,
  input  logic [NrHarts-1:0]           eoc_valid_i,
  input  logic [NrHarts*CodeWidth-1:0] eoc_code_i,
  output logic [NrHarts-1:0]           hart_done_o,
  output logic [CntWidth-1:0]          cycle_cnt_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic                         timeout_o,
  output logic [CodeWidth-1:0]         exit_code_o,
  output logic [HartW-1:0]             fail_hart_o
);

  localparam int unsigned HoldW = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;
  localparam logic [HoldW-1:0]    HoldLast    = HoldW'(ResetCycles - 1);
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);

  state_e              state_q, state_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [CntWidth-1:0] cnt_q;
  logic                dut_rst_q, done_q, pass_q, timeout_q;
  logic                all_done_c, fail_seen_c;

  sim_eoc_tracker #(
    .NrHarts   (NrHarts),
    .CodeWidth (CodeWidth)
  ) u_tracker (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (state_q == RUN),
    .eoc_valid_i (eoc_valid_i),
    .eoc_code_i  (eoc_code_i),
    .hart_done_o (hart_done_o),
    .exit_code_o (exit_code_o),
    .fail_hart_o (fail_hart_o),
    .all_done_c  (all_done_c),
    .fail_seen_c (fail_seen_c)
  );

  // State and hold counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HOLD;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next state; completion takes priority over the watchdog.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      HOLD: begin
        hold_d = hold_q + HoldW'(1);
        if (hold_q == HoldLast) state_d = RUN;
      end
      RUN: begin
        if (all_done_c) begin
          state_d = DONE;
        end else if (TimeoutCycles != 0 && cnt_q == TimeoutLast) begin
          state_d = TIMEOUT;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Registered outputs; everything freezes once DONE/TIMEOUT is reached.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dut_rst_q <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      dut_rst_q <= (state_d != HOLD);
      if (state_q == RUN) begin
        if (cnt_q != '1) cnt_q <= cnt_q + CntWidth'(1);
        if (state_d == DONE) begin
          done_q <= 1'b1;
          pass_q <= !fail_seen_c;
        end else if (state_d == TIMEOUT) begin
          done_q    <= 1'b1;
          timeout_q <= 1'b1;
        end
      end
    end
  end

  assign dut_rst_no  = dut_rst_q;
  assign cycle_cnt_o = cnt_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;

`ifdef SIM_RUN_CTRL_FINISH_EN
`ifndef SYNTHESIS
  logic done_seen_q, finish_q;

  // Report once on the first cycle with done_o high, end the run a cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_seen_q <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      done_seen_q <= done_q;
      finish_q    <= done_q && !done_seen_q;
      if (done_q && !done_seen_q) begin
        $display("sim_run_ctrl: %s exit_code=0x%0h hart=%0d cycles=%0d",
                 timeout_q ? "TIMEOUT" : (pass_q ? "PASS" : "FAIL"),
                 exit_code_q_dbg(), fail_hart_o, cnt_q);
      end
      if (finish_q) $finish;
    end
  end

  function automatic logic [CodeWidth-1:0] exit_code_q_dbg();
    return exit_code_o;
  endfunction
`endif
`endif

endmodule
